// File: rtl/idli_pkg.sv
// Shared widths for the IDLI register path.
//   greg_t     : general register index (8 registers)
//   sqi_data_t : one nibble of a 16b register, moved per phase
package idli_pkg;
  typedef logic [2:0] greg_t;
  typedef logic [3:0] sqi_data_t;
endpackage

// File: rtl/idli_regs_seq_m.sv
// Register file write sequencer.
// A free-running 2b phase counter selects which nibble of a 16b register
// is on the read/write ports. Two requesters (ALU, memory load) compete
// for the single write port. A winner is chosen once per 4-cycle window
// (in phase 3). It then owns the port for the next phases 0..3 and streams
// one nibble per phase.
//
// Ports
//   i_rsq_gck                clock
//   i_rsq_rst                synchronous active-high reset
//   i_rsq_alu_req/reg/data   ALU write request, destination, nibble
//   o_rsq_alu_gnt            ALU owns the write port this cycle
//   i_rsq_mem_req/reg/data   memory-load write request, destination, nibble
//   o_rsq_mem_gnt            memory requester owns the write port this cycle
//   o_rsq_wr/_en/_data       register file write index, enable, nibble
//   o_rsq_phase              current nibble phase
//   o_rsq_busy               a write transfer is in progress
//
// state    | meaning
// ---------+------------------------------------------------
// IDLE     | no owner for this 4-cycle window, write port off
// XFER_ALU | ALU streams nibbles 0..3 into its register
// XFER_MEM | memory requester streams nibbles 0..3
module idli_regs_seq_m
  import idli_pkg::*;
(
  input  logic      i_rsq_gck,
  input  logic      i_rsq_rst,
  input  logic      i_rsq_alu_req,
  input  greg_t     i_rsq_alu_reg,
  input  sqi_data_t i_rsq_alu_data,
  output logic      o_rsq_alu_gnt,
  input  logic      i_rsq_mem_req,
  input  greg_t     i_rsq_mem_reg,
  input  sqi_data_t i_rsq_mem_data,
  output logic      o_rsq_mem_gnt,
  output greg_t     o_rsq_wr,
  output logic      o_rsq_wr_en,
  output sqi_data_t o_rsq_wr_data,
  output logic [1:0] o_rsq_phase,
  output logic      o_rsq_busy
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_XFER_ALU = 2'd1,
    ST_XFER_MEM = 2'd2
  } state_t;

  state_t     state;
  logic [1:0] phase;
  // 1: memory requester wins the next tie; 0: ALU wins it.
  logic       rr_mem_pref;

  always_ff @(posedge i_rsq_gck) begin
    if (i_rsq_rst) begin
      phase         <= 2'd0;
      state         <= ST_IDLE;
      rr_mem_pref   <= 1'b1;
      o_rsq_alu_gnt <= 1'b0;
      o_rsq_mem_gnt <= 1'b0;
    end else begin
      phase <= phase + 2'd1;
      // The window boundary: decide the owner of the next phases 0..3.
      // Requests outside phase 3 are not looked at, so an in-flight
      // transfer always runs to completion.
      if (phase == 2'd3) begin
        if (i_rsq_alu_req && (!i_rsq_mem_req || !rr_mem_pref)) begin
          state         <= ST_XFER_ALU;
          o_rsq_alu_gnt <= 1'b1;
          o_rsq_mem_gnt <= 1'b0;
          rr_mem_pref   <= 1'b1;
        end else if (i_rsq_mem_req) begin
          state         <= ST_XFER_MEM;
          o_rsq_alu_gnt <= 1'b0;
          o_rsq_mem_gnt <= 1'b1;
          rr_mem_pref   <= 1'b0;
        end else begin
          state         <= ST_IDLE;
          o_rsq_alu_gnt <= 1'b0;
          o_rsq_mem_gnt <= 1'b0;
        end
      end
    end
  end

  // Write port follows the owner's inputs combinationally so the nibble
  // for phase N lands in phase N without an extra pipeline stage.
  always_comb begin
    o_rsq_wr_en   = 1'b0;
    o_rsq_wr      = '0;
    o_rsq_wr_data = '0;
    case (state)
      ST_XFER_ALU: begin
        o_rsq_wr_en   = 1'b1;
        o_rsq_wr      = i_rsq_alu_reg;
        o_rsq_wr_data = i_rsq_alu_data;
      end
      ST_XFER_MEM: begin
        o_rsq_wr_en   = 1'b1;
        o_rsq_wr      = i_rsq_mem_reg;
        o_rsq_wr_data = i_rsq_mem_data;
      end
      default: ;
    endcase
  end

  assign o_rsq_phase = phase;
  assign o_rsq_busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_idli_regs_seq_m.sv
// Directed bench for idli_regs_seq_m. Inputs change 2 time units after the
// rising edge; outputs are sampled 1 unit later, mid-cycle.
module tb_idli_regs_seq_m;
  import idli_pkg::*;

  logic      clk = 1'b0;
  logic      rst;
  logic      alu_req, mem_req;
  greg_t     alu_reg, mem_reg;
  sqi_data_t alu_data, mem_data;
  logic      alu_gnt, mem_gnt, wr_en, busy;
  greg_t     wr;
  sqi_data_t wr_data;
  logic [1:0] phase;

  int errors = 0;
  int checks = 0;

  // Register file model fed from the write port.
  logic [15:0] rf [8];

  always #5 clk = ~clk;

  idli_regs_seq_m dut (
    .i_rsq_gck      (clk),
    .i_rsq_rst      (rst),
    .i_rsq_alu_req  (alu_req),
    .i_rsq_alu_reg  (alu_reg),
    .i_rsq_alu_data (alu_data),
    .o_rsq_alu_gnt  (alu_gnt),
    .i_rsq_mem_req  (mem_req),
    .i_rsq_mem_reg  (mem_reg),
    .i_rsq_mem_data (mem_data),
    .o_rsq_mem_gnt  (mem_gnt),
    .o_rsq_wr       (wr),
    .o_rsq_wr_en    (wr_en),
    .o_rsq_wr_data  (wr_data),
    .o_rsq_phase    (phase),
    .o_rsq_busy     (busy)
  );

  always @(posedge clk)
    if (wr_en) rf[wr][{phase, 2'b00} +: 4] <= wr_data;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic outs(input string tag, input logic ag, input logic mg, input logic we,
                      input logic [2:0] w, input logic [3:0] d, input logic [1:0] ph,
                      input logic bz);
    #1;
    chk({tag, ".alu_gnt"}, 16'(alu_gnt), 16'(ag));
    chk({tag, ".mem_gnt"}, 16'(mem_gnt), 16'(mg));
    chk({tag, ".wr_en"},   16'(wr_en),   16'(we));
    chk({tag, ".wr"},      16'(wr),      16'(w));
    chk({tag, ".wr_data"}, 16'(wr_data), 16'(d));
    chk({tag, ".phase"},   16'(phase),   16'(ph));
    chk({tag, ".busy"},    16'(busy),    16'(bz));
  endtask

  initial begin
    rst = 1'b1;
    alu_req = 1'b0; alu_reg = '0; alu_data = '0;
    mem_req = 1'b0; mem_reg = '0; mem_data = '0;
    tick();
    tick();
    rst = 1'b0;

    // First cycle after reset, then a 9-cycle idle run showing the wrap.
    for (int i = 0; i < 9; i++) begin
      if (i > 0) tick();
      outs("idle_wrap", 1'b0, 1'b0, 1'b0, 3'd0, 4'h0, 2'(i % 4), 1'b0);
    end

    // ALU request rises in phase 1: granted 3 cycles later at phase 0.
    tick();
    alu_req = 1'b1; alu_reg = 3'd5; mem_reg = 3'd2; mem_data = 4'hF;
    outs("late_p1", 1'b0, 1'b0, 1'b0, 3'd0, 4'h0, 2'd1, 1'b0);
    tick();
    outs("late_p1", 1'b0, 1'b0, 1'b0, 3'd0, 4'h0, 2'd2, 1'b0);
    tick();
    outs("late_p1", 1'b0, 1'b0, 1'b0, 3'd0, 4'h0, 2'd3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      alu_data = 4'(i + 1);
      if (i == 3) alu_req = 1'b0;
      outs("alu_r5", 1'b1, 1'b0, 1'b1, 3'd5, 4'(i + 1), 2'(i), 1'b1);
    end
    tick();
    alu_data = 4'h0;
    outs("alu_r5_end", 1'b0, 1'b0, 1'b0, 3'd0, 4'h0, 2'd0, 1'b0);
    chk("r5_value", rf[5], 16'h4321);

    // Memory request rising in phase 3 is granted on the next cycle.
    tick();
    outs("idle2", 1'b0, 1'b0, 1'b0, 3'd0, 4'h0, 2'd1, 1'b0);
    tick();
    outs("idle2", 1'b0, 1'b0, 1'b0, 3'd0, 4'h0, 2'd2, 1'b0);
    tick();
    mem_req = 1'b1;
    outs("late_p3", 1'b0, 1'b0, 1'b0, 3'd0, 4'h0, 2'd3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      mem_data = 4'(4'hA + i);
      if (i == 3) mem_req = 1'b0;
      outs("mem_r2", 1'b0, 1'b1, 1'b1, 3'd2, 4'(4'hA + i), 2'(i), 1'b1);
    end
    chk("r2_pending", 16'(mem_gnt & alu_gnt), 16'h0);

    // Reset in phase 2 of an ALU transfer.
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) begin
        alu_req = 1'b1; alu_data = 4'h7;
      end
      outs("idle3", 1'b0, 1'b0, 1'b0, 3'd0, 4'h0, 2'(i), 1'b0);
    end
    tick();
    outs("pre_rst", 1'b1, 1'b0, 1'b1, 3'd5, 4'h7, 2'd0, 1'b1);
    tick();
    outs("pre_rst", 1'b1, 1'b0, 1'b1, 3'd5, 4'h7, 2'd1, 1'b1);
    tick();
    rst = 1'b1;
    outs("pre_rst", 1'b1, 1'b0, 1'b1, 3'd5, 4'h7, 2'd2, 1'b1);
    tick();
    rst = 1'b0;
    outs("after_rst", 1'b0, 1'b0, 1'b0, 3'd0, 4'h0, 2'd0, 1'b0);
    for (int i = 1; i < 4; i++) begin
      tick();
      outs("rst_wait", 1'b0, 1'b0, 1'b0, 3'd0, 4'h0, 2'(i), 1'b0);
    end
    // Request dropped in the first transfer cycle: transfer still completes.
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) alu_req = 1'b0;
      outs("post_rst", 1'b1, 1'b0, 1'b1, 3'd5, 4'h7, 2'(i), 1'b1);
    end

    // Reset again, then both requesters held: mem, alu, mem, alu.
    tick();
    rst = 1'b1;
    outs("rr_rst", 1'b0, 1'b0, 1'b0, 3'd0, 4'h0, 2'd0, 1'b0);
    tick();
    rst = 1'b0;
    alu_req = 1'b1; alu_reg = 3'd1; alu_data = 4'h3;
    mem_req = 1'b1; mem_reg = 3'd6; mem_data = 4'hC;
    outs("rr_wait", 1'b0, 1'b0, 1'b0, 3'd0, 4'h0, 2'd0, 1'b0);
    for (int i = 1; i < 4; i++) begin
      tick();
      outs("rr_wait", 1'b0, 1'b0, 1'b0, 3'd0, 4'h0, 2'(i), 1'b0);
    end
    for (int c = 0; c < 16; c++) begin
      logic mem_win;
      tick();
      if (c == 15) begin
        alu_req = 1'b0; mem_req = 1'b0;
      end
      mem_win = ((c / 4) % 2) == 0;
      outs("rr", !mem_win, mem_win, 1'b1, mem_win ? 3'd6 : 3'd1,
           mem_win ? 4'hC : 4'h3, 2'(c % 4), 1'b1);
    end
    tick();
    outs("rr_end", 1'b0, 1'b0, 1'b0, 3'd0, 4'h0, 2'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
